dup_lock_fsm: RTL and testbench

DUP_LOCK_FSM -- requirements
Module: dup_lock_fsm

---
 rtl/dup_lock_pkg.sv | 17 +
 rtl/key_copy_sel.sv | 25 ++
 rtl/dup_lock_fsm.sv | 142 ++++++++++++++
 tb/tb_dup_lock_fsm.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dup_lock_pkg.sv
// Shared types for the duplicate-state locked accumulator.
// State kinds and stage-index width helper.
package dup_lock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STG   = 2'd1,
    STG_D = 2'd2,
    DONE  = 2'd3
  } kind_e;

  // Stage index width; a single stage still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_copy_sel.sv
// Picks the true (0) or duplicate (1) copy of a stage
// from the key bit belonging to that stage.
module key_copy_sel
  import dup_lock_pkg::*;
#(
  parameter int                KEY_W   = 4,
  parameter logic [KEY_W-1:0]  KEY_VAL = 4'b1010,
  parameter int                IW      = idx_w(KEY_W)
) (
  input  logic [KEY_W-1:0] i_key,
  input  logic [IW-1:0]    i_idx,
  output logic             o_copy
);

  // A key bit that differs from the correct one selects the duplicate.
  always_comb begin
    o_copy = 1'b0;
    for (int k = 0; k < KEY_W; k++) begin
      if (i_idx == IW'(k)) begin
        o_copy = i_key[k] ^ KEY_VAL[k];
      end
    end
  end

endmodule

// File: rtl/dup_lock_fsm.sv
// Keyed accumulator FSM with true/duplicate stage copies.
// Wrong key bits route stages through corrupting duplicates.
module dup_lock_fsm
  import dup_lock_pkg::*;
#(
  parameter int               KEY_W   = 4,
  parameter logic [KEY_W-1:0] KEY_VAL = 4'b1010,
  parameter int               DW      = 8,
  parameter int               MODE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  input  logic [KEY_W-1:0] keyinput,
  output logic             din_ready,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int IW = idx_w(KEY_W);
  localparam logic [IW-1:0] LAST = IW'(KEY_W - 1);

  kind_e          r_kind;
  kind_e          w_kind_nxt;
  logic [IW-1:0]  r_idx;
  logic [IW-1:0]  w_idx_nxt;
  logic           r_copy;
  logic           w_copy_nxt;
  logic [DW-1:0]  r_acc;
  logic [DW-1:0]  w_acc_nxt;
  logic [DW-1:0]  r_dout;
  logic [DW-1:0]  w_dout_nxt;
  logic [DW-1:0]  w_addend;
  logic [IW-1:0]  w_sel_idx;
  logic           w_sel_copy;
  logic           w_idx_ok;
  logic           w_stage_ok;

  // Stage about to be entered: 0 from IDLE, else the next one.
  assign w_sel_idx = (r_kind == IDLE) ? '0 : r_idx + IW'(1);

  key_copy_sel #(
    .KEY_W   (KEY_W),
    .KEY_VAL (KEY_VAL),
    .IW      (IW)
  ) u_sel (
    .i_key  (keyinput),
    .i_idx  (w_sel_idx),
    .o_copy (w_sel_copy)
  );

  // Stage encodings are legal only in range and with a matching copy bit.
  always_comb begin
    w_idx_ok = 1'b0;
    for (int k = 0; k < KEY_W; k++) begin
      if (r_idx == IW'(k)) begin
        w_idx_ok = 1'b1;
      end
    end
    w_stage_ok = w_idx_ok && (r_copy == (r_kind == STG_D));
  end

  // Duplicate copies inject the inverted beat when corrupting.
  assign w_addend =
    ((r_kind == STG_D) && (MODE == 1)) ? ~din : din;

  // State register, accumulator and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kind <= IDLE;
      r_idx  <= '0;
      r_copy <= 1'b0;
      r_acc  <= '0;
      r_dout <= '0;
    end else begin
      r_kind <= w_kind_nxt;
      r_idx  <= w_idx_nxt;
      r_copy <= w_copy_nxt;
      r_acc  <= w_acc_nxt;
      r_dout <= w_dout_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_kind_nxt = r_kind;
    w_idx_nxt  = r_idx;
    w_copy_nxt = r_copy;
    w_acc_nxt  = r_acc;
    w_dout_nxt = r_dout;
    unique case (r_kind)
      IDLE: begin
        if (start) begin
          w_kind_nxt = w_sel_copy ? STG_D : STG;
          w_idx_nxt  = '0;
          w_copy_nxt = w_sel_copy;
          w_acc_nxt  = '0;
        end
      end
      STG, STG_D: begin
        if (!w_stage_ok) begin
          w_kind_nxt = IDLE;
          w_idx_nxt  = '0;
          w_copy_nxt = 1'b0;
          w_acc_nxt  = '0;
        end else if (din_valid) begin
          w_acc_nxt = r_acc + w_addend;
          if (r_idx == LAST) begin
            w_kind_nxt = DONE;
            w_idx_nxt  = '0;
            w_copy_nxt = 1'b0;
            w_dout_nxt = r_acc + w_addend;
          end else begin
            w_kind_nxt = w_sel_copy ? STG_D : STG;
            w_idx_nxt  = w_sel_idx;
            w_copy_nxt = w_sel_copy;
          end
        end
      end
      DONE: begin
        w_kind_nxt = IDLE;
        w_idx_nxt  = '0;
        w_copy_nxt = 1'b0;
      end
      default: begin
        w_kind_nxt = IDLE;
        w_idx_nxt  = '0;
        w_copy_nxt = 1'b0;
        w_acc_nxt  = '0;
      end
    endcase
  end

  assign din_ready  = (r_kind == STG) || (r_kind == STG_D);
  assign busy       = (r_kind != IDLE);
  assign dout_valid = (r_kind == DONE);
  assign dout       = r_dout;

endmodule

// File: tb/tb_dup_lock_fsm.sv
// Directed bench for dup_lock_fsm, MODE=1 and MODE=0
// instances driven in parallel.
module tb_dup_lock_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic       din_valid;
  logic [3:0] keyinput;
  logic       rdy1, dv1, busy1;
  logic       rdy0, dv0, busy0;
  logic [7:0] dout1, dout0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dup_lock_fsm #(
    .KEY_W(4), .KEY_VAL(4'b1010), .DW(8), .MODE(1)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .din(din), .din_valid(din_valid),
    .keyinput(keyinput), .din_ready(rdy1),
    .dout(dout1), .dout_valid(dv1), .busy(busy1)
  );

  dup_lock_fsm #(
    .KEY_W(4), .KEY_VAL(4'b1010), .DW(8), .MODE(0)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .din(din), .din_valid(din_valid),
    .keyinput(keyinput), .din_ready(rdy0),
    .dout(dout0), .dout_valid(dv0), .busy(busy0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  // One full run; inputs change and outputs are read on negedges.
  task automatic run(input string tag,
                     input logic [3:0] key,
                     input logic [7:0] b0, b1, b2, b3,
                     input int gap,
                     input logic [7:0] e1, e0);
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    @(negedge clk);
    keyinput = key;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy1, 1);
    chk({tag, "_rdy"}, rdy1, 1);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        din_valid = 1'b0;
        din = 8'hff;
        @(negedge clk);
        chk({tag, "_gap_rdy1"}, rdy1, 1);
        chk({tag, "_gap_rdy0"}, rdy0, 1);
        chk({tag, "_gap_dv"}, dv1, 0);
      end
      din = b[i];
      din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    chk({tag, "_dv1"}, dv1, 1);
    chk({tag, "_dv0"}, dv0, 1);
    chk({tag, "_dout1"}, dout1, e1);
    chk({tag, "_dout0"}, dout0, e0);
    chk({tag, "_done_rdy"}, rdy1, 0);
    @(negedge clk);
    chk({tag, "_post_dv"}, dv1, 0);
    chk({tag, "_post_busy"}, busy1, 0);
    chk({tag, "_hold1"}, dout1, e1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    din = 8'd55;
    din_valid = 1'b1;
    keyinput = 4'b1010;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_rdy", rdy1, 0);
    chk("rst_dv", dv1, 0);
    chk("rst_dout", dout1, 0);
    chk("rst_busy0", busy0, 0);
    rst = 1'b0;
    start = 1'b0;
    din_valid = 1'b0;

    run("ok", 4'b1010, 8'd10, 8'd20, 8'd30, 8'd40, 0,
        8'd100, 8'd100);
    run("bit0", 4'b1011, 8'd10, 8'd20, 8'd30, 8'd40, 0,
        8'd79, 8'd100);
    run("allbad", 4'b0101, 8'd10, 8'd20, 8'd30, 8'd40, 0,
        8'd152, 8'd100);
    run("wrap", 4'b1010, 8'd200, 8'd100, 8'd0, 8'd0, 0,
        8'd44, 8'd44);
    run("gaps", 4'b1010, 8'd200, 8'd100, 8'd0, 8'd0, 3,
        8'd44, 8'd44);

    // Abort in stage 2.
    @(negedge clk);
    keyinput = 4'b1010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din = 8'd10;
    din_valid = 1'b1;
    @(negedge clk);
    din = 8'd20;
    @(negedge clk);
    din_valid = 1'b0;
    chk("abort_pre_busy", busy1, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy1, 0);
    chk("abort_rdy", rdy1, 0);
    chk("abort_dout", dout1, 0);
    chk("abort_dv", dv1, 0);
    din_valid = 1'b1;
    din = 8'd30;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_dv", dv1, 0);
    end
    din_valid = 1'b0;

    // Start pulse and key changes mid-stage; copy set at entry only.
    @(negedge clk);
    keyinput = 4'b1010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din = 8'd10;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    keyinput = 4'b0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("tog_busy", busy1, 1);
    chk("tog_rdy", rdy1, 1);
    keyinput = 4'b1110;
    din = 8'd20;
    din_valid = 1'b1;
    @(negedge clk);
    keyinput = 4'b1010;
    din = 8'd30;
    @(negedge clk);
    din = 8'd40;
    @(negedge clk);
    din_valid = 1'b0;
    chk("tog_dv1", dv1, 1);
    chk("tog_dout1", dout1, 39);
    chk("tog_dout0", dout0, 100);
    @(negedge clk);
    chk("tog_post_busy", busy1, 0);
    chk("tog_post_dv", dv1, 0);

    // Stray din_valid while idle leaves the result alone.
    din_valid = 1'b1;
    din = 8'd7;
    repeat (2) @(negedge clk);
    din_valid = 1'b0;
    chk("idle_dout", dout1, 39);
    chk("idle_rdy", rdy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
